serial_sub_8bit: RTL and testbench
==================================

# serial_sub_8bit

Bit-serial subtractor computing Diff = A − B − Bin, one bit per clock, LSB first. It is the sequential, inverse-operation counterpart to the parallel ripple-carry adder: same operand widths and the same borrow-in/borrow-out convention in place of carry-in/carry-out. It sits behind a start/done handshake so a controller can issue operands and collect a registered result. It trades latency for a single-bit datapath.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin; sampled only when not busy.
- A  input  WIDTH  minuend; latched on the accepted start edge.
- B  input  WIDTH  subtrahend; latched on the accepted start edge.
- Bin  input  1  borrow-in; latched on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid and updated.
- Diff  output  WIDTH  registered result; held between operations.
- Bout  output  1  final borrow-out; 1 when A < B + Bin (unsigned).

## Operation
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, Diff=0, Bout=0.
  - Internal shift registers, bit counter and borrow flop are cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 latches A, B and Bin into the shift and borrow registers, clears the counter, and moves to SHIFT.
  - SHIFT: each edge consumes bit 0 of both shift registers:
    - d = a ^ b ^ br.
    - br' = (~a & b) | (~(a ^ b) & br).
    - d shifts into the MSB of the result shift register; both operand registers shift right.
    - The counter increments. On the edge that processes bit WIDTH−1, the state moves to DONE, Diff takes the complete result and Bout takes br'.
  - DONE: done=1 for exactly one cycle, then the state goes to IDLE.
    - start=1 in DONE is accepted exactly as in IDLE; the next state is SHIFT.
- start while in SHIFT is ignored. It is neither queued nor does it disturb the operands.
- Diff and Bout change only on the transition into DONE. During SHIFT they hold the previous result.
- The operation is modulo 2^WIDTH with no saturation. 0 − 1 gives all-ones with Bout=1.
- Inputs A, B and Bin may change freely after the accepting edge.

## Timing
- The accepting edge is E0. busy=1 from E0 through the edge at which the result is produced.
- Bits are processed on edges E1..E_WIDTH.
- Diff, Bout and done are valid after edge E_WIDTH. For WIDTH=8, done is high in the cycle following the 8th edge after acceptance.
- busy=0 in the cycle that done=1.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts, because start is accepted in DONE.
- Reset asserted mid-SHIFT aborts immediately and clears everything, with no done pulse. The first start after rst_n deasserts is sampled on the next rising edge.

## Configuration
- SERIAL_SUB_OVERFLOW_EN:
  - Defined: adds output port V (1 bit), updated with Diff/Bout. V = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]) using the latched operands; this is signed two's-complement overflow. V is reset to 0.
  - Undefined: V does not exist, and no logic for it is built.

## Test plan
- Reset then A=0x00, B=0x00, Bin=0, start -> done after 8 edges, Diff=0x00, Bout=0; busy high during the 8 bit cycles.
- A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1 (wrap-around); with SERIAL_SUB_OVERFLOW_EN, V=0.
- A=0x55, B=0xAA, Bin=1 -> Diff=0xAA, Bout=1; V=1. Then A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, V=1.
- Issue start (A=0x10, B=0x03) and pulse start again with A=0xFF during SHIFT -> second start ignored; Diff=0x0D, Bout=0; previous Diff held until done.
- Hold start high continuously over exhaustive 8-bit A/B/Bin (with random sampling acceptable) -> a done pulse every 9 cycles, each matching {Bout, Diff} = A − B − Bin mod 2^9 negated-borrow model.
- Assert rst_n=0 at bit 4 of an operation -> busy, done, Diff and Bout all 0 asynchronously; no done pulse follows. A new operation after release completes correctly.

Source files
------------

// File: rtl/serial_sub_8bit_if.sv
// serial_sub_8bit_if: start/done handshake and operand/result bus for serial_sub_8bit.
// V exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_sub_8bit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             V;
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout, V);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, V);
`else
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_sub_8bit.sv
// serial_sub_8bit: bit-serial A - B - Bin, LSB first, behind a start/done handshake.
// Optional signed-overflow output V under SERIAL_SUB_OVERFLOW_EN.
module serial_sub_8bit #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_sub_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_d;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;
    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    assign w_a      = r_a[0];
    assign w_b      = r_b[0];
    assign w_d      = w_a ^ w_b ^ r_br;
    assign w_br     = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_res    = {w_d, r_d};
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = bus.start && r_state != SHIFT;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    // operand MSBs are kept aside because the operand registers shift away
    logic r_v;
    logic r_am;
    logic r_bm;
    assign bus.V = r_v;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= 1'b0;
            r_am <= 1'b0;
            r_bm <= 1'b0;
        end else if (w_accept) begin
            r_am <= bus.A[WIDTH-1];
            r_bm <= bus.B[WIDTH-1];
        end else if (r_state == SHIFT && w_last) begin
            r_v <= (r_am != r_bm) && (w_res[WIDTH-1] != r_am);
        end
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state <= SHIFT;
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_br    <= bus.Bin;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_d   <= w_res[WIDTH-1:1];
                r_br  <= w_br;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_diff  <= w_res;
                    r_bout  <= w_br;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_8bit.sv
// tb_serial_sub_8bit: directed and random checks of serial_sub_8bit against a 9-bit arithmetic model.
module tb_serial_sub_8bit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] exp_diff = '0;
    logic       exp_bout = 1'b0;
    logic       exp_v    = 1'b0;
    logic [8:0] q_res[$];
    logic       q_v[$];
    serial_sub_8bit_if #(.WIDTH(8)) bus ();
    serial_sub_8bit #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [8:0] r, output logic v);
        r = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        v = (a[7] != b[7]) && (r[7] != a[7]);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".diff"}, 32'(bus.Diff), 32'(exp_diff));
        chk({tag, ".bout"}, 32'(bus.Bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({tag, ".v"}, 32'(bus.V), 32'(exp_v));
`endif
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input string tag, input bit glitch);
        logic [8:0] r;
        logic       v;
        model(a, b, bi, r, v);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = 8'($urandom); bus.B = 8'($urandom); bus.Bin = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
            chk({tag, ".done_run"}, 32'(bus.done), 32'd0);
            chk({tag, ".diff_hold"}, 32'(bus.Diff), 32'(exp_diff));
            if (glitch && i == 3) begin
                bus.start = 1'b1; bus.A = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        exp_diff = r[7:0]; exp_bout = r[8]; exp_v = v;
        chk_result(tag);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.diff", 32'(bus.Diff), 32'd0);
        chk("rst.bout", 32'(bus.Bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op(8'h00, 8'h00, 1'b0, "zero", 1'b0);
        op(8'h00, 8'h01, 1'b0, "wrap", 1'b0);
        op(8'h55, 8'hAA, 1'b1, "alt", 1'b0);
        op(8'h80, 8'h01, 1'b0, "ovf", 1'b0);
        op(8'h10, 8'h03, 1'b0, "ignore", 1'b1);
        op(8'hFF, 8'hFF, 1'b1, "allones", 1'b0);
        repeat (6) op(8'($urandom), 8'($urandom), 1'($urandom), "rand", 1'b0);
        // start held high: a new operand set is taken on every DONE edge
        for (int k = 0; k < 24; k++) begin
            logic [8:0] r;
            logic       v;
            bus.start = 1'b1;
            bus.A = 8'($urandom); bus.B = 8'($urandom); bus.Bin = 1'($urandom);
            model(bus.A, bus.B, bus.Bin, r, v);
            q_res.push_back(r);
            q_v.push_back(v);
            for (int j = 1; j <= 9; j++) begin
                @(negedge clk);
                if (j < 9) chk("stream.done_gap", 32'(bus.done), 32'd0);
            end
            r = q_res.pop_front();
            v = q_v.pop_front();
            exp_diff = r[7:0]; exp_bout = r[8]; exp_v = v;
            chk_result("stream");
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("stream.end_done", 32'(bus.done), 32'd0);
        chk("stream.end_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.A = 8'h3C; bus.B = 8'h0F; bus.Bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.done", 32'(bus.done), 32'd0);
        chk("arst.diff", 32'(bus.Diff), 32'd0);
        chk("arst.bout", 32'(bus.Bout), 32'd0);
        exp_diff = '0; exp_bout = 1'b0; exp_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("arst.no_done", 32'(bus.done), 32'd0);
            chk("arst.idle", 32'(bus.busy), 32'd0);
        end
        op(8'h10, 8'h20, 1'b1, "post_rst", 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
